dbf_fine_coef_sched: RTL and testbench

//  Supplies the fine-delay interpolator with per-channel h0/h1 coefficient pairs.

---
 rtl/dbf_fine_coef_sched.sv | 159 +++++++++++++++
 tb/tb_dbf_fine_coef_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbf_fine_coef_sched.sv
// Fine-delay coefficient scheduler: tracks the TDM channel slot and serves per-channel h0/h1 from a
// double-buffered table whose shadow->active swap happens only on a frame boundary.
module dbf_fine_coef_sched #(
  parameter int FILTER_COFF = 16,
  parameter int NUM_CH      = 8,
  parameter int CH_W        = 3,
  parameter logic signed [FILTER_COFF-1:0] UNITY = 16'sh4000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_wr_en,
  input  logic [CH_W-1:0]               cfg_ch,
  input  logic signed [FILTER_COFF-1:0] cfg_h0,
  input  logic signed [FILTER_COFF-1:0] cfg_h1,
  input  logic                          cfg_commit,
  output logic                          cfg_busy,
  output logic                          cfg_err,
  input  logic                          frame_start,
  input  logic                          sample_valid,
  output logic signed [FILTER_COFF-1:0] h0,
  output logic signed [FILTER_COFF-1:0] h1,
  output logic [CH_W-1:0]               ch_idx,
  output logic                          coef_valid,
  output logic                          frame_err
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   NUM_CH_EX = (CH_W + 1)'(NUM_CH);

  state_t state_q, state_d;
  logic [CH_W-1:0] cnt_q, cnt_d;
  logic wrap_q, wrap_d;
  logic active_q, active_d;
  logic pending_q, pending_d;
  logic signed [FILTER_COFF-1:0] h0_bank_q [2][NUM_CH];
  logic signed [FILTER_COFF-1:0] h0_bank_d [2][NUM_CH];
  logic signed [FILTER_COFF-1:0] h1_bank_q [2][NUM_CH];
  logic signed [FILTER_COFF-1:0] h1_bank_d [2][NUM_CH];
  logic signed [FILTER_COFF-1:0] h0_q, h0_d, h1_q, h1_d;
  logic [CH_W-1:0] ch_idx_q, ch_idx_d;
  logic coef_valid_q, coef_valid_d;
  logic frame_err_q, frame_err_d;
  logic cfg_err_q, cfg_err_d;

  logic run_sample;
  logic [CH_W-1:0] slot;
  logic shadow_sel;
  logic wr_in_range;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wrap_d       = wrap_q;
    active_d     = active_q;
    pending_d    = pending_q;
    h0_bank_d    = h0_bank_q;
    h1_bank_d    = h1_bank_q;
    h0_d         = h0_q;
    h1_d         = h1_q;
    ch_idx_d     = ch_idx_q;
    coef_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    cfg_err_d    = 1'b0;
    slot         = cnt_q;
    shadow_sel   = ~active_q;
    wr_in_range  = ({1'b0, cfg_ch} < NUM_CH_EX);
    run_sample   = sample_valid && ((state_q == S_RUN) || frame_start);

    if (frame_start) state_d = S_RUN;

    // wrap_q marks that the counter rolled over without a frame_start, so the next ch-0
    // sample is a frame overrun rather than the legitimate first sample after frame_start.
    if (frame_start) begin
      slot   = '0;
      cnt_d  = sample_valid ? CH_W'(1) : '0;
      wrap_d = 1'b0;
      if ((state_q == S_RUN) && (cnt_q != '0)) frame_err_d = 1'b1;
    end else if (run_sample) begin
      if ((cnt_q == '0) && wrap_q) frame_err_d = 1'b1;
      if (cnt_q == LAST_CH) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CH_W'(1);
      end
    end

    if (frame_start && pending_q) begin
      active_d  = ~active_q;
      pending_d = 1'b0;
    end

    if (cfg_wr_en) begin
      if (!pending_q && wr_in_range) begin
        h0_bank_d[shadow_sel][cfg_ch] = cfg_h0;
        h1_bank_d[shadow_sel][cfg_ch] = cfg_h1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (cfg_commit && !pending_q) pending_d = 1'b1;

    // Read with active_d so the ch-0 sample of a swapping frame already sees the new bank.
    if (run_sample) begin
      coef_valid_d = 1'b1;
      ch_idx_d     = slot;
      h0_d         = h0_bank_q[active_d][slot];
      h1_d         = h1_bank_q[active_d][slot];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wrap_q       <= 1'b0;
      active_q     <= 1'b0;
      pending_q    <= 1'b0;
      h0_q         <= '0;
      h1_q         <= '0;
      ch_idx_q     <= '0;
      coef_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          h0_bank_q[b][c] <= UNITY;
          h1_bank_q[b][c] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wrap_q       <= wrap_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      h0_q         <= h0_d;
      h1_q         <= h1_d;
      ch_idx_q     <= ch_idx_d;
      coef_valid_q <= coef_valid_d;
      frame_err_q  <= frame_err_d;
      cfg_err_q    <= cfg_err_d;
      h0_bank_q    <= h0_bank_d;
      h1_bank_q    <= h1_bank_d;
    end
  end

  assign h0         = h0_q;
  assign h1         = h1_q;
  assign ch_idx     = ch_idx_q;
  assign coef_valid = coef_valid_q;
  assign frame_err  = frame_err_q;
  assign cfg_err    = cfg_err_q;
  assign cfg_busy   = pending_q;

endmodule

// File: tb/tb_dbf_fine_coef_sched.sv
// Directed bench for dbf_fine_coef_sched: an 8-channel instance for the main checks and a
// 6-channel instance sharing the stimulus for the out-of-range write check.
module tb_dbf_fine_coef_sched;

  logic clk;
  logic reset;
  logic cfg_wr_en;
  logic [2:0] cfg_ch;
  logic signed [15:0] cfg_h0, cfg_h1;
  logic cfg_commit;
  logic frame_start;
  logic sample_valid;

  logic cfg_busy, cfg_err, coef_valid, frame_err;
  logic signed [15:0] h0, h1;
  logic [2:0] ch_idx;

  logic cfg_busy_6, cfg_err_6, coef_valid_6, frame_err_6;
  logic signed [15:0] h0_6, h1_6;
  logic [2:0] ch_idx_6;

  int checks;
  int failures;

  dbf_fine_coef_sched #(.FILTER_COFF(16), .NUM_CH(8), .CH_W(3), .UNITY(16'sh4000)) dut (
    .clk(clk), .reset(reset),
    .cfg_wr_en(cfg_wr_en), .cfg_ch(cfg_ch), .cfg_h0(cfg_h0), .cfg_h1(cfg_h1),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .frame_start(frame_start), .sample_valid(sample_valid),
    .h0(h0), .h1(h1), .ch_idx(ch_idx), .coef_valid(coef_valid), .frame_err(frame_err)
  );

  dbf_fine_coef_sched #(.FILTER_COFF(16), .NUM_CH(6), .CH_W(3), .UNITY(16'sh4000)) dut6 (
    .clk(clk), .reset(reset),
    .cfg_wr_en(cfg_wr_en), .cfg_ch(cfg_ch), .cfg_h0(cfg_h0), .cfg_h1(cfg_h1),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy_6), .cfg_err(cfg_err_6),
    .frame_start(frame_start), .sample_valid(sample_valid),
    .h0(h0_6), .h1(h1_6), .ch_idx(ch_idx_6), .coef_valid(coef_valid_6), .frame_err(frame_err_6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_wr_en    = 1'b0;
    cfg_ch       = 3'd0;
    cfg_h0       = 16'sh0;
    cfg_h1       = 16'sh0;
    cfg_commit   = 1'b0;
    frame_start  = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (coef_valid !== 1'b0 || h0 !== 16'sh0 || h1 !== 16'sh0 || ch_idx !== 3'd0 ||
        cfg_busy !== 1'b0 || cfg_err !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b h0=%h h1=%h ch=%0d busy=%b cerr=%b ferr=%b, want all 0",
               coef_valid, h0, h1, ch_idx, cfg_busy, cfg_err, frame_err);
    end
    sample_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (coef_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignores_sample: coef_valid got %b want 0", coef_valid);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_range_err();
    cfg_wr_en = 1'b1;
    cfg_ch    = 3'd6;
    cfg_h0    = 16'sh4000;
    cfg_h1    = 16'sh0;
    tick();
    idle_inputs();
    checks++;
    if (cfg_err_6 !== 1'b1 || cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL range_err: cfg_err6 got %b want 1, cfg_err8 got %b want 0", cfg_err_6, cfg_err);
    end
    tick();
    checks++;
    if (cfg_err_6 !== 1'b0) begin
      failures++;
      $display("FAIL range_err_pulse: cfg_err6 got %b want 0", cfg_err_6);
    end
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < 8; i++) begin
      frame_start  = (i == 0);
      sample_valid = 1'b1;
      tick();
      checks++;
      if (coef_valid !== 1'b1 || ch_idx !== 3'(i) || h0 !== 16'sh4000 || h1 !== 16'sh0 || frame_err !== 1'b0) begin
        failures++;
        $display("FAIL basic_frame[%0d]: got v=%b ch=%0d h0=%h h1=%h ferr=%b want 1/%0d/4000/0000/0",
                 i, coef_valid, ch_idx, h0, h1, frame_err, i);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (coef_valid !== 1'b0 || ch_idx !== 3'd7 || h0 !== 16'sh4000) begin
      failures++;
      $display("FAIL basic_hold: got v=%b ch=%0d h0=%h want 0/7/4000", coef_valid, ch_idx, h0);
    end
  endtask

  task automatic test_commit_midframe();
    frame_start = 1'b1; sample_valid = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    sample_valid = 1'b0;
    cfg_wr_en = 1'b1; cfg_ch = 3'd3; cfg_h0 = 16'sh2000; cfg_h1 = 16'sh2000;
    tick();
    cfg_wr_en = 1'b0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    checks++;
    if (cfg_busy !== 1'b1) begin
      failures++;
      $display("FAIL commit_busy: cfg_busy got %b want 1", cfg_busy);
    end
    cfg_wr_en = 1'b1; cfg_ch = 3'd3; cfg_h0 = 16'sh1111; cfg_h1 = 16'sh1111;
    tick();
    cfg_wr_en = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin
      failures++;
      $display("FAIL busy_write_err: cfg_err got %b want 1", cfg_err);
    end
    for (int i = 2; i < 8; i++) begin
      sample_valid = 1'b1;
      tick();
      checks++;
      if (ch_idx !== 3'(i) || h0 !== 16'sh4000 || h1 !== 16'sh0 || cfg_err !== 1'b0) begin
        failures++;
        $display("FAIL pre_swap[%0d]: got ch=%0d h0=%h h1=%h cerr=%b want %0d/4000/0000/0",
                 i, ch_idx, h0, h1, cfg_err, i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      frame_start = (i == 0);
      sample_valid = 1'b1;
      tick();
      checks++;
      if (ch_idx !== 3'(i) || h0 !== ((i == 3) ? 16'sh2000 : 16'sh4000) ||
          h1 !== ((i == 3) ? 16'sh2000 : 16'sh0) || cfg_busy !== 1'b0 || frame_err !== 1'b0) begin
        failures++;
        $display("FAIL post_swap[%0d]: got ch=%0d h0=%h h1=%h busy=%b ferr=%b",
                 i, ch_idx, h0, h1, cfg_busy, frame_err);
      end
    end
    idle_inputs();
  endtask

  task automatic test_commit_with_frame_start();
    for (int i = 0; i < 8; i++) begin
      frame_start = (i == 0);
      cfg_commit  = (i == 0);
      sample_valid = 1'b1;
      tick();
      checks++;
      if (ch_idx !== 3'(i) || h0 !== ((i == 3) ? 16'sh2000 : 16'sh4000) || cfg_busy !== 1'b1) begin
        failures++;
        $display("FAIL no_swap_same_cycle[%0d]: got ch=%0d h0=%h busy=%b want h0=%h busy=1",
                 i, ch_idx, h0, cfg_busy, (i == 3) ? 16'sh2000 : 16'sh4000);
      end
    end
    cfg_commit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      frame_start = (i == 0);
      sample_valid = 1'b1;
      tick();
      checks++;
      if (ch_idx !== 3'(i) || h0 !== 16'sh4000 || h1 !== 16'sh0 || cfg_busy !== 1'b0) begin
        failures++;
        $display("FAIL deferred_swap[%0d]: got ch=%0d h0=%h h1=%h busy=%b want 4000/0000/0",
                 i, ch_idx, h0, h1, cfg_busy);
      end
    end
    idle_inputs();
  endtask

  task automatic test_frame_err();
    frame_start = 1'b1; sample_valid = 1'b1;
    tick();
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL aligned_frame_start: frame_err got %b want 0", frame_err);
    end
    frame_start = 1'b0;
    repeat (4) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (frame_err !== 1'b1 || ch_idx !== 3'd0) begin
      failures++;
      $display("FAIL short_frame: got ferr=%b ch=%0d want 1/0", frame_err, ch_idx);
    end
    tick();
    checks++;
    if (frame_err !== 1'b0 || ch_idx !== 3'd1) begin
      failures++;
      $display("FAIL short_frame_pulse: got ferr=%b ch=%0d want 0/1", frame_err, ch_idx);
    end
    repeat (6) tick();
    checks++;
    if (frame_err !== 1'b0 || ch_idx !== 3'd7) begin
      failures++;
      $display("FAIL full_frame_no_err: got ferr=%b ch=%0d want 0/7", frame_err, ch_idx);
    end
    tick();
    checks++;
    if (frame_err !== 1'b1 || ch_idx !== 3'd0) begin
      failures++;
      $display("FAIL long_frame: got ferr=%b ch=%0d want 1/0", frame_err, ch_idx);
    end
    idle_inputs();
    tick();
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL long_frame_pulse: frame_err got %b want 0", frame_err);
    end
  endtask

  task automatic test_reset_midframe();
    frame_start = 1'b1; sample_valid = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    sample_valid = 1'b0;
    cfg_wr_en = 1'b1; cfg_ch = 3'd2; cfg_h0 = 16'sh1234; cfg_h1 = 16'sh0567;
    cfg_commit = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (cfg_busy !== 1'b1) begin
      failures++;
      $display("FAIL write_commit_busy: cfg_busy got %b want 1", cfg_busy);
    end
    sample_valid = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (coef_valid !== 1'b0 || h0 !== 16'sh0 || h1 !== 16'sh0 || ch_idx !== 3'd0 || cfg_busy !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset: got v=%b h0=%h h1=%h ch=%0d busy=%b want all 0",
               coef_valid, h0, h1, ch_idx, cfg_busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (coef_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_reset[%0d]: coef_valid got %b want 0", i, coef_valid);
      end
    end
    for (int i = 0; i < 8; i++) begin
      frame_start = (i == 0);
      tick();
      checks++;
      if (coef_valid !== 1'b1 || ch_idx !== 3'(i) || h0 !== 16'sh4000 || h1 !== 16'sh0 || cfg_busy !== 1'b0) begin
        failures++;
        $display("FAIL tables_after_reset[%0d]: got v=%b ch=%0d h0=%h h1=%h busy=%b want 1/%0d/4000/0000/0",
                 i, coef_valid, ch_idx, h0, h1, cfg_busy, i);
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_range_err();
    test_basic_frame();
    test_commit_midframe();
    test_commit_with_frame_start();
    test_frame_err();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
